// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter that owns the select of a shared N:1 data mux,
// with a hold limit so a busy owner is rotated out when others are waiting.
module mux_rr_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] sel,
  output logic [W-1:0]         y,
  output logic                 y_valid
);
  localparam int SW = $clog2(N);
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t        r_state, w_state;
  logic [SW-1:0] r_ptr, w_ptr, r_sel, w_sel, w_pick, w_idx;
  logic [HW-1:0] r_hold, w_hold;
  logic [N-1:0]  r_gnt, w_gnt, w_others, w_cand;
  logic          w_new;
  assign w_others = req & ~(N'(1) << r_sel);
  assign w_cand   = r_state == IDLE ? req : w_others;
  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    w_pick = '0;
    w_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = SW'((int'(r_ptr) + i) % N);
      if (w_cand[w_idx]) w_pick = w_idx;
    end
  end
  assign w_new = r_state == IDLE ? |req
               : !req[r_sel]     ? |w_others
               : (r_hold == HMAX && |w_others);
  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_sel   = r_sel;
    w_ptr   = r_ptr;
    w_hold  = r_hold;
    if (w_new) begin
      w_state = GRANT;
      w_gnt   = N'(1) << w_pick;
      w_sel   = w_pick;
      w_ptr   = w_pick == SW'(N - 1) ? '0 : w_pick + SW'(1);
      w_hold  = '0;
    end else if (r_state == GRANT && !req[r_sel]) begin
      w_state = IDLE;
      w_gnt   = '0;
      w_hold  = '0;
    end else if (r_state == GRANT) begin
      w_hold  = r_hold == HMAX ? r_hold : r_hold + HW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_sel   <= w_sel;
      r_ptr   <= w_ptr;
      r_hold  <= w_hold;
    end
  end
  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign y_valid = |r_gnt;
  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++)
      if (y_valid && r_sel == SW'(k)) y = in_data[k*W +: W];
  end
endmodule
